// File: rtl/fir_out_pkg.sv
// Shared types, default constants and the rounding helper for the FIR output conditioner.
package fir_out_pkg;

   typedef enum logic {
      WARMUP = 1'b0,
      RUN    = 1'b1
   } state_t;

   localparam int FIR_OUT_IN_W     = 20;
   localparam int FIR_OUT_FILL_LAT = 17;

   // Round-half-up right shift carried at 33 bits so the rounding carry is never lost.
   function automatic logic [32:0] round_shift(input logic [31:0] value, input int unsigned shift);
      logic [32:0] sum;
      sum = {1'b0, value} + (33'd1 << (shift - 1));
      return sum >> shift;
   endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// First-word-fall-through FIFO; head entry is presented straight from the storage registers.
module fir_out_fifo
   import fir_out_pkg::*;
#(
   parameter int W     = 12,
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [W-1:0]             wr_data,
   input  logic                     rd_en,
   output logic [W-1:0]             rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_wr, do_rd;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_rd    = rd_en && (count_q != '0);
      // A full FIFO still accepts a write when the head leaves in the same cycle.
      do_wr    = wr_en && ((count_q != CW'(DEPTH)) || do_rd);
      if (do_wr) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_rd) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_wr, do_rd})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign count   = count_q;
   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);

endmodule

// File: rtl/fir_output_conditioner.sv
// Drops FIR warm-up samples, decimates, rounds/fits to OUT_W and queues results on a valid/ready stream.
// Build option: define FIR_OUT_SATURATE_EN to clamp oversized results instead of wrapping.
module fir_output_conditioner
   import fir_out_pkg::*;
#(
   parameter int IN_W     = FIR_OUT_IN_W,
   parameter int OUT_W    = 12,
   parameter int SHIFT    = 8,
   parameter int DECIM    = 1,
   parameter int FILL_LAT = FIR_OUT_FILL_LAT,
   parameter int DEPTH    = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [IN_W-1:0]          in_data,
   input  logic                     in_en,
   output logic [OUT_W-1:0]         out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow
);

   localparam int WC_W = $clog2(FILL_LAT + 1);
   localparam int DC_W = (DECIM > 1) ? $clog2(DECIM) : 1;

   state_t           state_q, state_d;
   logic [WC_W-1:0]  warm_cnt_q, warm_cnt_d;
   logic [DC_W-1:0]  decim_cnt_q, decim_cnt_d;
   logic             keep;
   logic [32:0]      r_full;
   logic [OUT_W-1:0] fit;
   logic             stg_vld_p1_q, stg_vld_p1_d;
   logic [OUT_W-1:0] stg_data_p1_q, stg_data_p1_d;
   logic             overflow_q, overflow_d;
   logic             fifo_full, fifo_empty, pop;

   always_comb begin
      state_d     = state_q;
      warm_cnt_d  = warm_cnt_q;
      decim_cnt_d = decim_cnt_q;
      keep        = 1'b0;
      case (state_q)
         WARMUP: begin
            if (in_en) begin
               if (warm_cnt_q == WC_W'(FILL_LAT - 1)) begin
                  state_d    = RUN;
                  warm_cnt_d = '0;
               end else begin
                  warm_cnt_d = warm_cnt_q + WC_W'(1);
               end
            end
         end
         RUN: begin
            if (in_en) begin
               keep        = (decim_cnt_q == '0);
               decim_cnt_d = (decim_cnt_q == DC_W'(DECIM - 1)) ? '0 : decim_cnt_q + DC_W'(1);
            end
         end
         default: state_d = WARMUP;
      endcase
   end

   always_comb begin
      r_full = round_shift(32'(in_data), SHIFT);
`ifdef FIR_OUT_SATURATE_EN
      fit = (r_full > 33'((64'd1 << OUT_W) - 64'd1)) ? '1 : r_full[OUT_W-1:0];
`else
      fit = r_full[OUT_W-1:0];
`endif
   end

`ifndef FIR_OUT_SATURATE_EN
   logic unused_r_hi;
   assign unused_r_hi = ^r_full[32:OUT_W];
`endif

   always_comb begin
      stg_vld_p1_d  = keep;
      stg_data_p1_d = keep ? fit : stg_data_p1_q;
      pop           = out_valid & out_ready;
      overflow_d    = overflow_q | (stg_vld_p1_q & fifo_full & ~pop);
   end

   // Stage p1: rounded sample waits one clock before entering the FIFO.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= WARMUP;
         warm_cnt_q    <= '0;
         decim_cnt_q   <= '0;
         stg_vld_p1_q  <= 1'b0;
         stg_data_p1_q <= '0;
         overflow_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         warm_cnt_q    <= warm_cnt_d;
         decim_cnt_q   <= decim_cnt_d;
         stg_vld_p1_q  <= stg_vld_p1_d;
         stg_data_p1_q <= stg_data_p1_d;
         overflow_q    <= overflow_d;
      end
   end

   fir_out_fifo #(
      .W     (OUT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (stg_vld_p1_q),
      .wr_data (stg_data_p1_q),
      .rd_en   (out_ready),
      .rd_data (out_data),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign out_valid = ~fifo_empty;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_fir_output_conditioner.sv
// Bench for fir_output_conditioner: two instances (DECIM=1 and DECIM=4) on shared stimulus,
// checked every cycle against a sample-index/queue reference model plus directed expectations.
module tb_fir_output_conditioner;

   localparam int DEPTH = 4;
   localparam int FL    = 17;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [19:0] in_data = '0;
   logic        in_en = 1'b0;
   logic        out_ready = 1'b0;

   logic [11:0] o1_data, o4_data;
   logic        o1_valid, o4_valid;
   logic [2:0]  o1_count, o4_count;
   logic        o1_ovf, o4_ovf;

   int n_cmp = 0;
   int n_err = 0;

   logic        msv [2];
   logic [11:0] msd [2];
   logic [11:0] mbuf [2][DEPTH];
   int          msidx [2];
   int          mhead [2];
   int          mcnt [2];
   logic        movf [2];

   logic        collect4 = 1'b0;
   logic [11:0] col4 [$];
   logic [11:0] exp_big;

   always #5 clock = ~clock;

   fir_output_conditioner u_dut1 (
      .clock(clock), .reset(reset), .in_data(in_data), .in_en(in_en),
      .out_data(o1_data), .out_valid(o1_valid), .out_ready(out_ready),
      .fifo_count(o1_count), .overflow(o1_ovf)
   );

   fir_output_conditioner #(.DECIM(4)) u_dut4 (
      .clock(clock), .reset(reset), .in_data(in_data), .in_en(in_en),
      .out_data(o4_data), .out_valid(o4_valid), .out_ready(out_ready),
      .fifo_count(o4_count), .overflow(o4_ovf)
   );

   function automatic logic [11:0] expect_val(input logic [19:0] x);
      int r;
      r = (int'(x) + 128) / 256;
`ifdef FIR_OUT_SATURATE_EN
      if (r > 4095) r = 4095;
      return 12'(r);
`else
      return 12'(r % 4096);
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 2; i++) begin
         msv[i] = 1'b0; msd[i] = '0; msidx[i] = 0;
         mhead[i] = 0; mcnt[i] = 0; movf[i] = 1'b0;
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         int  d;
         bit  pop;
         d   = (i == 0) ? 1 : 4;
         pop = (mcnt[i] > 0) && out_ready;
         if (pop) begin
            mhead[i] = (mhead[i] + 1) % DEPTH;
            mcnt[i]--;
         end
         if (msv[i]) begin
            if (mcnt[i] < DEPTH) begin
               mbuf[i][(mhead[i] + mcnt[i]) % DEPTH] = msd[i];
               mcnt[i]++;
            end else begin
               movf[i] = 1'b1;
            end
         end
         msv[i] = in_en && (msidx[i] >= FL) && (((msidx[i] - FL) % d) == 0);
         if (msv[i]) msd[i] = expect_val(in_data);
         if (in_en) msidx[i]++;
      end
   endtask

   task automatic compare_model();
      check("u1_valid", 32'(o1_valid), 32'(mcnt[0] > 0));
      check("u1_count", 32'(o1_count), 32'(mcnt[0]));
      check("u1_ovf",   32'(o1_ovf),   32'(movf[0]));
      if (mcnt[0] > 0) check("u1_data", 32'(o1_data), 32'(mbuf[0][mhead[0]]));
      check("u4_valid", 32'(o4_valid), 32'(mcnt[1] > 0));
      check("u4_count", 32'(o4_count), 32'(mcnt[1]));
      check("u4_ovf",   32'(o4_ovf),   32'(movf[1]));
      if (mcnt[1] > 0) check("u4_data", 32'(o4_data), 32'(mbuf[1][mhead[1]]));
   endtask

   task automatic tick();
      if (!reset) model_clear();
      else        model_step();
      @(posedge clock);
      @(negedge clock);
      compare_model();
      if (collect4 && o4_valid && out_ready) col4.push_back(o4_data);
   endtask

   task automatic drive(input logic en, input logic [19:0] data);
      in_en   = en;
      in_data = data;
      tick();
   endtask

   task automatic do_reset(input int hold);
      reset = 1'b0;
      model_clear();
      #1;
      check("rst_valid1", 32'(o1_valid), 32'd0);
      check("rst_count1", 32'(o1_count), 32'd0);
      check("rst_ovf1",   32'(o1_ovf),   32'd0);
      check("rst_valid4", 32'(o4_valid), 32'd0);
      @(negedge clock);
      for (int i = 0; i < hold; i++) tick();
      reset = 1'b1;
   endtask

   initial begin
`ifdef FIR_OUT_SATURATE_EN
      exp_big = 12'hFFF;
`else
      exp_big = 12'h000;
`endif
      model_clear();
      #2 reset = 1'b0;
      #1;
      check("rst_data1",  32'(o1_data),  32'd0);
      check("rst_data4",  32'(o4_data),  32'd0);
      check("rst_valid1", 32'(o1_valid), 32'd0);
      check("rst_count1", 32'(o1_count), 32'd0);
      check("rst_ovf1",   32'(o1_ovf),   32'd0);
      @(negedge clock);
      tick();
      tick();
      reset = 1'b1;
      out_ready = 1'b1;

      // Warm-up discard, then first kept sample two clocks later.
      for (int i = 0; i < FL; i++) begin
         drive(1'b1, 20'hFFFFF);
         check("warm_valid", 32'(o1_valid), 32'd0);
      end
      drive(1'b1, 20'd4096);
      check("lat1_valid", 32'(o1_valid), 32'd0);
      drive(1'b0, 20'd0);
      check("lat2_valid", 32'(o1_valid), 32'd1);
      check("first_data", 32'(o1_data), 32'd16);
      check("first_data4", 32'(o4_data), 32'd16);
      drive(1'b0, 20'd0);

      // Rounding boundaries.
      drive(1'b1, 20'd384);
      drive(1'b1, 20'd383);
      check("rnd_384", 32'(o1_data), 32'd2);
      drive(1'b1, 20'd128);
      check("rnd_383", 32'(o1_data), 32'd1);
      drive(1'b1, 20'd127);
      check("rnd_128", 32'(o1_data), 32'd1);
      drive(1'b0, 20'd0);
      check("rnd_127", 32'(o1_data), 32'd0);
      drive(1'b0, 20'd0);

      // Full-scale input: clamp or wrap.
      drive(1'b1, 20'hFFFFF);
      drive(1'b0, 20'd0);
      check("fit_big", 32'(o1_data), 32'(exp_big));
      drive(1'b0, 20'd0);

      // Decimation by 4 with in_en gaps.
      do_reset(1);
      for (int i = 0; i < FL; i++) drive(1'b1, 20'($urandom));
      collect4 = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         drive(1'b1, 20'(k * 256));
         if (k % 2 == 1) drive(1'b0, 20'($urandom));
      end
      for (int i = 0; i < 4; i++) drive(1'b0, 20'd0);
      collect4 = 1'b0;
      check("dec_n", 32'(col4.size()), 32'd2);
      if (col4.size() == 2) begin
         check("dec_0", 32'(col4[0]), 32'd1);
         check("dec_1", 32'(col4[1]), 32'd5);
      end

      // Backpressure and overflow.
      out_ready = 1'b0;
      for (int k = 0; k < 6; k++) drive(1'b1, 20'((k + 10) * 256));
      drive(1'b0, 20'd0);
      drive(1'b0, 20'd0);
      check("ovf_count", 32'(o1_count), 32'd4);
      check("ovf_flag",  32'(o1_ovf),   32'd1);
      out_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         check("ovf_order_v", 32'(o1_valid), 32'd1);
         check("ovf_order_d", 32'(o1_data), 32'(10 + j));
         drive(1'b0, 20'd0);
      end
      check("ovf_drained", 32'(o1_valid), 32'd0);
      check("ovf_sticky",  32'(o1_ovf),   32'd1);

      // Reset with entries queued.
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) drive(1'b1, 20'((k + 1) * 256));
      drive(1'b0, 20'd0);
      drive(1'b0, 20'd0);
      check("q3_count", 32'(o1_count), 32'd3);
      do_reset(1);
      out_ready = 1'b1;
      for (int i = 0; i < FL; i++) begin
         drive(1'b1, 20'($urandom));
         check("rewarm_valid", 32'(o1_valid), 32'd0);
      end
      drive(1'b1, 20'd1792);
      drive(1'b0, 20'd0);
      check("rewarm_out_v", 32'(o1_valid), 32'd1);
      check("rewarm_out_d", 32'(o1_data), 32'd7);

      // Randomised traffic with a mid-run reset.
      for (int c = 0; c < 400; c++) begin
         if (c == 200) do_reset(2);
         out_ready = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 9) == 0) drive(1'b1, 20'hFFF00 | 20'($urandom_range(0, 255)));
         else drive($urandom_range(0, 3) != 0, 20'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
